// File: rtl/mesm6_bus_arbiter.sv
// Round-robin arbiter merging the mesm6 instruction and data buses onto one single-port word memory.
// Optional one-entry fetched-word buffer enabled by defining MESM6_IFETCH_BUF_EN.
module mesm6_bus_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ibus_fetch,
  input  logic [14:0] ibus_addr,
  output logic [47:0] ibus_input,
  output logic        ibus_done,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [14:0] dbus_addr,
  input  logic [47:0] dbus_output,
  output logic [47:0] dbus_input,
  output logic        dbus_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [47:0] mem_wdata,
  input  logic [47:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_I = 3'd1,
    WAIT_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  state_t           state_r;
  logic             last_grant_r;  // 1 = data port was granted last
  logic [CNT_W-1:0] cnt_r;

  logic             d_pend_s;
  logic             grant_i_s;
  logic             grant_d_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             timeout_s;
  logic             buf_hit_s;
  logic [47:0]      buf_data_s;

  // Grant decision and saturating timeout detection
  always_comb begin
    d_pend_s  = dbus_read | dbus_write;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (ibus_fetch && d_pend_s) begin
      grant_i_s = last_grant_r;
      grant_d_s = ~last_grant_r;
    end else begin
      grant_i_s = ibus_fetch;
      grant_d_s = d_pend_s;
    end
    if (cnt_r == {CNT_W{1'b1}}) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (TIMEOUT == 0) begin
      timeout_s = 1'b0;
    end else begin
      timeout_s = (cnt_inc_s == CNT_W'(TIMEOUT));
    end
  end

`ifdef MESM6_IFETCH_BUF_EN
  logic        buf_valid_r;
  logic [14:0] buf_tag_r;
  logic [47:0] buf_data_r;

  assign buf_hit_s  = buf_valid_r && (ibus_addr == buf_tag_r);
  assign buf_data_s = buf_data_r;

  // Fetched-word buffer: fill on successful fetch, drop on aliasing write or bus error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid_r <= 1'b0;
      buf_tag_r   <= 15'd0;
      buf_data_r  <= 48'd0;
    end else if (state_r == WAIT_I && mem_ack) begin
      buf_valid_r <= 1'b1;
      buf_tag_r   <= mem_addr;
      buf_data_r  <= mem_rdata;
    end else if ((state_r == IDLE && grant_d_s && dbus_write && dbus_addr == buf_tag_r) ||
                 ((state_r == WAIT_I || state_r == WAIT_D) && !mem_ack && timeout_s)) begin
      buf_valid_r <= 1'b0;
    end else begin
      buf_valid_r <= buf_valid_r;
    end
  end
`else
  assign buf_hit_s  = 1'b0;
  assign buf_data_s = 48'd0;
`endif

  // Transaction FSM with registered memory-side and core-side outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      cnt_r        <= {CNT_W{1'b0}};
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 15'd0;
      mem_wdata    <= 48'd0;
      ibus_input   <= 48'd0;
      dbus_input   <= 48'd0;
      ibus_done    <= 1'b0;
      dbus_done    <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      ibus_done <= 1'b0;
      dbus_done <= 1'b0;
      bus_error <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (grant_i_s) begin
            last_grant_r <= 1'b0;
            if (buf_hit_s) begin
              ibus_input <= buf_data_s;
              ibus_done  <= 1'b1;
              state_r    <= RESP_I;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= ibus_addr;
              mem_wdata <= 48'd0;
              state_r   <= WAIT_I;
            end
          end else if (grant_d_s) begin
            last_grant_r <= 1'b1;
            mem_req      <= 1'b1;
            mem_we       <= dbus_write;
            mem_addr     <= dbus_addr;
            mem_wdata    <= dbus_output;
            state_r      <= WAIT_D;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_I: begin
          if (mem_ack) begin
            ibus_input <= mem_rdata;
            mem_req    <= 1'b0;
            ibus_done  <= 1'b1;
            state_r    <= RESP_I;
          end else if (timeout_s) begin
            ibus_input <= 48'd0;
            mem_req    <= 1'b0;
            ibus_done  <= 1'b1;
            bus_error  <= 1'b1;
            state_r    <= RESP_I;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        WAIT_D: begin
          if (mem_ack) begin
            if (!mem_we) begin
              dbus_input <= mem_rdata;
            end else begin
              dbus_input <= dbus_input;
            end
            mem_req   <= 1'b0;
            dbus_done <= 1'b1;
            state_r   <= RESP_D;
          end else if (timeout_s) begin
            if (!mem_we) begin
              dbus_input <= 48'd0;
            end else begin
              dbus_input <= dbus_input;
            end
            mem_req   <= 1'b0;
            dbus_done <= 1'b1;
            bus_error <= 1'b1;
            state_r   <= RESP_D;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        RESP_I, RESP_D: begin
          // The core still presents the request just answered, so it is not sampled here.
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mesm6_bus_arbiter.sv
// Directed scoreboard bench for mesm6_bus_arbiter with a wait-state memory model.
module tb_mesm6_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ibus_fetch = 1'b0;
  logic [14:0] ibus_addr = 15'd0;
  logic [47:0] ibus_input;
  logic        ibus_done;
  logic        dbus_read = 1'b0;
  logic        dbus_write = 1'b0;
  logic [14:0] dbus_addr = 15'd0;
  logic [47:0] dbus_output = 48'd0;
  logic [47:0] dbus_input;
  logic        dbus_done;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [47:0] mem_wdata;
  logic [47:0] mem_rdata = 48'd0;
  logic        mem_ack = 1'b0;
  logic        bus_error;

  mesm6_bus_arbiter #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr), .ibus_input(ibus_input), .ibus_done(ibus_done),
    .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
    .dbus_output(dbus_output), .dbus_input(dbus_input), .dbus_done(dbus_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port_d;
    logic [47:0] data;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [47:0] mem [int];
  int          wait_cfg = 0;
  bit          ack_off = 1'b0;
  int          wcnt = 0;
  logic [47:0] last_d = 48'd0;
  int          k;

  function automatic logic [47:0] rd(input logic [14:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    else return {16'hA5A5, 17'd0, a};
  endfunction

  // Memory model: acks after wait_cfg wait states, writes commit on the ack cycle
  always @(negedge clk) begin
    if (mem_req && !ack_off) begin
      if (wcnt == wait_cfg) begin
        mem_ack   = 1'b1;
        mem_rdata = rd(mem_addr);
        if (mem_we) mem[int'(mem_addr)] = mem_wdata;
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit port_d, input logic [47:0] data, input bit err);
    exp_t e;
    e.port_d = port_d; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 48'd1, 48'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_idone"}, {47'd0, ibus_done}, {47'd0, !e.port_d});
      check({tag, "_ddone"}, {47'd0, dbus_done}, {47'd0, e.port_d});
      check({tag, "_data"}, e.port_d ? dbus_input : ibus_input, e.data);
      check({tag, "_berr"}, {47'd0, bus_error}, {47'd0, e.err});
    end
  endtask

  task automatic wait_done(input string tag, input int max_cyc, output int kk);
    kk = 0;
    do begin
      @(negedge clk);
      kk++;
    end while (!(ibus_done || dbus_done) && kk < max_cyc);
    if (ibus_done || dbus_done) pop_check(tag);
    else check({tag, "_bound"}, 48'd0, 48'd1);
  endtask

  initial begin
    mem[int'(15'h0123)] = 48'h0A0B0C0D0E0F;
    repeat (2) @(negedge clk);
    check("rst_mem_req", {47'd0, mem_req}, 48'd0);
    check("rst_mem_we", {47'd0, mem_we}, 48'd0);
    check("rst_mem_addr", {33'd0, mem_addr}, 48'd0);
    check("rst_mem_wdata", mem_wdata, 48'd0);
    check("rst_ibus_input", ibus_input, 48'd0);
    check("rst_dbus_input", dbus_input, 48'd0);
    check("rst_dones", {46'd0, ibus_done, dbus_done}, 48'd0);
    check("rst_berr", {47'd0, bus_error}, 48'd0);
    reset = 1'b1;
    @(negedge clk);

    // Contention from reset: I first, then alternating, back-to-back 3 cycles each
    ibus_fetch = 1'b1; ibus_addr = 15'h0100;
    dbus_read = 1'b1; dbus_addr = 15'h0200;
    push_exp(1'b0, rd(15'h0100), 1'b0);
    push_exp(1'b1, rd(15'h0200), 1'b0);
    push_exp(1'b0, rd(15'h0100), 1'b0);
    push_exp(1'b1, rd(15'h0200), 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_done("rr", 6, k);
      check("rr_lat", 48'(k), (i == 0) ? 48'd2 : 48'd3);
    end
    ibus_fetch = 1'b0; dbus_read = 1'b0;
    last_d = rd(15'h0200);
    @(negedge clk);

    // Write with 3 wait states: stable request for 4 cycles, done@5, dbus_input kept
    wait_cfg = 3;
    dbus_write = 1'b1; dbus_addr = 15'h7FFF; dbus_output = 48'hFFFFFFFFFFFF;
    push_exp(1'b1, last_d, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("wr_req", {45'd0, mem_req, mem_we, dbus_done}, 48'd6);
      check("wr_addr", {33'd0, mem_addr}, 48'h7FFF);
      check("wr_wdata", mem_wdata, 48'hFFFFFFFFFFFF);
    end
    @(negedge clk);
    pop_check("wr");
    dbus_write = 1'b0; dbus_output = 48'd0;
    @(negedge clk);

    wait_cfg = 0;
    dbus_read = 1'b1;
    push_exp(1'b1, 48'hFFFFFFFFFFFF, 1'b0);
    wait_done("rdback", 6, k);
    check("rdback_lat", 48'(k), 48'd2);
    dbus_read = 1'b0;
    @(negedge clk);

    // Single fetch, zero wait: done@2, one-cycle pulse
    ibus_fetch = 1'b1; ibus_addr = 15'h0123;
    push_exp(1'b0, 48'h0A0B0C0D0E0F, 1'b0);
    wait_done("fetch", 6, k);
    check("fetch_lat", 48'(k), 48'd2);
    ibus_fetch = 1'b0;
    @(negedge clk);
    check("fetch_pulse", {47'd0, ibus_done}, 48'd0);
    check("fetch_hold", ibus_input, 48'h0A0B0C0D0E0F);

    // Timeout: mem_req 4 cycles, then done+bus_error, dbus_input cleared
    ack_off = 1'b1;
    dbus_read = 1'b1; dbus_addr = 15'h0055;
    push_exp(1'b1, 48'd0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("to_req", {46'd0, mem_req, dbus_done}, 48'd2);
    end
    @(negedge clk);
    check("to_req_fall", {47'd0, mem_req}, 48'd0);
    pop_check("to");
    dbus_read = 1'b0;
    @(negedge clk);
    check("to_berr_pulse", {47'd0, bus_error}, 48'd0);

    // Asynchronous reset during WAIT_D
    dbus_read = 1'b1; dbus_addr = 15'h0066;
    repeat (2) @(negedge clk);
    check("ar_req_before", {47'd0, mem_req}, 48'd1);
    #2 reset = 1'b0;
    #1 check("ar_req_drop", {47'd0, mem_req}, 48'd0);
    check("ar_ibus_input", ibus_input, 48'd0);
    dbus_read = 1'b0; ack_off = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ibus_fetch = 1'b1; ibus_addr = 15'h0123;
    push_exp(1'b0, 48'h0A0B0C0D0E0F, 1'b0);
    wait_done("ar_fetch", 6, k);
    check("ar_fetch_lat", 48'(k), 48'd2);
    ibus_fetch = 1'b0;
    @(negedge clk);

`ifdef MESM6_IFETCH_BUF_EN
    ibus_fetch = 1'b1; ibus_addr = 15'h0010;
    push_exp(1'b0, rd(15'h0010), 1'b0);
    wait_done("buf_miss", 6, k);
    check("buf_miss_lat", 48'(k), 48'd2);
    ibus_fetch = 1'b0;
    @(negedge clk);
    ibus_fetch = 1'b1;
    push_exp(1'b0, rd(15'h0010), 1'b0);
    wait_done("buf_hit", 6, k);
    check("buf_hit_lat", 48'(k), 48'd1);
    check("buf_hit_noreq", {47'd0, mem_req}, 48'd0);
    ibus_fetch = 1'b0;
    @(negedge clk);
    dbus_write = 1'b1; dbus_addr = 15'h0010; dbus_output = 48'h123456789ABC;
    push_exp(1'b1, dbus_input, 1'b0);
    wait_done("buf_wr", 6, k);
    dbus_write = 1'b0;
    @(negedge clk);
    ibus_fetch = 1'b1; ibus_addr = 15'h0010;
    push_exp(1'b0, 48'h123456789ABC, 1'b0);
    wait_done("buf_inv", 6, k);
    check("buf_inv_lat", 48'(k), 48'd2);
    ibus_fetch = 1'b0;
    @(negedge clk);
`endif

    check("sb_drained", 48'(sb.size()), 48'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
